// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants, check-node FSM encoding and compressed check-node record.
// Imported by the check-to-bit message generator and its interface.
package ldpc_pkg;

    localparam int DEGREE  = 6;
    localparam int W       = 8;
    localparam int IDXW    = 3;
    localparam int MAG_MAX = 2 ** (W - 1) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Compressed check-node record as held between accept and the last emitted edge
    typedef struct packed {
        logic [IDXW-1:0]   min_idx;
        logic [W-1:0]      min_mag;
        logic [W-1:0]      smin_mag;
        logic [DEGREE-1:0] signs;
        logic              tot_sign;
    } rec_t;

endpackage

// File: rtl/check_to_bit_msg_gen_if.sv
// Record-in / message-out stream bundle of the check-node output stage.
// master = upstream finder + downstream consumer side, slave = the message generator.
interface check_to_bit_msg_gen_if;
    import ldpc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IDXW-1:0]   in_min_idx;
    logic [W-1:0]      in_min_mag;
    logic [W-1:0]      in_smin_mag;
    logic [DEGREE-1:0] in_signs;
    logic              out_valid;
    logic              out_ready;
    logic [IDXW-1:0]   out_idx;
    logic [W-1:0]      out_msg;
    logic              out_last;
    logic              out_parity_ok;

    modport master (
        output in_valid, in_min_idx, in_min_mag, in_smin_mag, in_signs, out_ready,
        input  in_ready, out_valid, out_idx, out_msg, out_last, out_parity_ok
    );

    modport slave (
        input  in_valid, in_min_idx, in_min_mag, in_smin_mag, in_signs, out_ready,
        output in_ready, out_valid, out_idx, out_msg, out_last, out_parity_ok
    );

endinterface

// File: rtl/cn_mag_select.sv
// Per-edge offset min-sum message: pick min/second-min, subtract offset, saturate, apply sign.
// Purely combinational, no handshake.
module cn_mag_select
    import ldpc_pkg::*;
#(
    parameter logic [W-2:0] OFFSET = '0
) (
    input  logic [IDXW-1:0] k,
    input  logic [IDXW-1:0] min_idx,
    input  logic [W-1:0]    min_mag,
    input  logic [W-1:0]    smin_mag,
    input  logic            sgn_k,
    output logic [W-1:0]    out_msg
);

    logic [W-1:0] sel;
    logic [W-1:0] off;
    logic [W-1:0] mag;

    always_comb begin
        sel = (k == min_idx) ? smin_mag : min_mag;
        off = (sel > {1'b0, OFFSET}) ? sel - {1'b0, OFFSET} : '0;
        // 2^(W-1) can arrive as a magnitude; clamp keeps it representable as positive
        mag = (off > W'(MAG_MAX)) ? W'(MAG_MAX) : off;
        out_msg = sgn_k ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/check_to_bit_msg_gen.sv
// Holds one compressed check-node record and streams DEGREE signed check-to-bit messages.
// Latency: record accepted in cycle N -> edge 0 valid in N+1; back-to-back records without bubbles.
// Backpressure: outputs held while out_ready low; in_ready only in IDLE or on the last-edge handshake.
module check_to_bit_msg_gen
    import ldpc_pkg::*;
#(
    parameter logic [W-2:0] OFFSET = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    check_to_bit_msg_gen_if.slave  bus
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEGREE - 1);

    state_t state;
    rec_t   rec;
    logic   fire;
    logic   accept;
    logic   sgn_k;

    assign fire        = bus.out_valid && bus.out_ready;
    assign bus.in_ready = (state == IDLE) || (fire && bus.out_last);
    assign accept      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rec               <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_idx       <= '0;
            bus.out_last      <= 1'b0;
            bus.out_parity_ok <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE start and the seamless hand-over on the last edge
            state             <= EMIT;
            rec.min_idx       <= bus.in_min_idx;
            rec.min_mag       <= bus.in_min_mag;
            rec.smin_mag      <= bus.in_smin_mag;
            rec.signs         <= bus.in_signs;
            rec.tot_sign      <= ^bus.in_signs;
            bus.out_valid     <= 1'b1;
            bus.out_idx       <= '0;
            bus.out_last      <= (DEGREE == 1);
            bus.out_parity_ok <= ~(^bus.in_signs);
        end else if (fire) begin
            if (bus.out_last) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_idx   <= '0;
                bus.out_last  <= 1'b0;
            end else begin
                bus.out_idx   <= bus.out_idx + 1'b1;
                bus.out_last  <= (bus.out_idx == LAST_IDX - 1'b1);
            end
        end
    end

    always_comb begin
        sgn_k = rec.tot_sign;
        for (int i = 0; i < DEGREE; i++) begin
            if (bus.out_idx == IDXW'(i)) begin
                sgn_k = rec.tot_sign ^ rec.signs[i];
            end
        end
    end

    cn_mag_select #(
        .OFFSET (OFFSET)
    ) u_mag_select (
        .k        (bus.out_idx),
        .min_idx  (rec.min_idx),
        .min_mag  (rec.min_mag),
        .smin_mag (rec.smin_mag),
        .sgn_k    (sgn_k),
        .out_msg  (bus.out_msg)
    );

endmodule

// File: tb/tb_check_to_bit_msg_gen.sv
// Scoreboard bench: two instances (OFFSET 0 and 2) share stimulus; a reference model predicts each message.
module tb_check_to_bit_msg_gen;
    import ldpc_pkg::*;

    typedef struct {
        int idx;
        int msg;
        bit last;
        bit par;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t q0[$];
    exp_t q1[$];
    bit   stalled[2];
    logic [IDXW+W+1:0] held[2];
    int   run[2];
    int   maxrun[2];
    int   beats[2];
    int   rmode;

    check_to_bit_msg_gen_if bus0 ();
    check_to_bit_msg_gen_if bus1 ();

    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.in_min_idx  = bus0.in_min_idx;
    assign bus1.in_min_mag  = bus0.in_min_mag;
    assign bus1.in_smin_mag = bus0.in_smin_mag;
    assign bus1.in_signs    = bus0.in_signs;
    assign bus1.out_ready   = bus0.out_ready;

    check_to_bit_msg_gen #(.OFFSET(7'd0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    check_to_bit_msg_gen #(.OFFSET(7'd2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offset min-sum from the arithmetic definition: extrinsic sign, extrinsic min, offset, clamp
    function automatic int model_msg(input int offset, input int k, input int mi,
                                     input int mn, input int smn, input bit [5:0] sg);
        bit tot;
        bit s;
        int sel;
        int off;
        int mag;
        tot = ^sg;
        s   = tot ^ sg[k];
        sel = (k == mi) ? smn : mn;
        off = (sel > offset) ? sel - offset : 0;
        mag = (off > 127) ? 127 : off;
        return s ? -mag : mag;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic r, input logic [IDXW-1:0] idx,
                       input logic [W-1:0] msg, input logic last, input logic par, input logic ir);
        exp_t e;
        bit   have;
        if (stalled[d] && v) check($sformatf("hold_dut%0d", d), int'({idx, msg, last, par}), int'(held[d]));
        if (v && !last) check($sformatf("in_ready_busy_dut%0d", d), int'(ir), 0);
        if (!v) check($sformatf("in_ready_idle_dut%0d", d), int'(ir), 1);
        if (v && r) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                check($sformatf("unexpected_msg_dut%0d", d), int'(idx), -1);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("idx_dut%0d", d), int'(idx), e.idx);
                check($sformatf("msg_dut%0d_idx%0d", d, e.idx), int'($signed(msg)), e.msg);
                check($sformatf("last_dut%0d_idx%0d", d, e.idx), int'(last), int'(e.last));
                check($sformatf("parity_dut%0d_idx%0d", d, e.idx), int'(par), int'(e.par));
                beats[d]++;
            end
        end
        stalled[d] = v && !r;
        held[d]    = {idx, msg, last, par};
        run[d]     = v ? run[d] + 1 : 0;
        if (run[d] > maxrun[d]) maxrun[d] = run[d];
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus0.out_valid, bus0.out_ready, bus0.out_idx, bus0.out_msg,
                bus0.out_last, bus0.out_parity_ok, bus0.in_ready);
            mon(1, bus1.out_valid, bus1.out_ready, bus1.out_idx, bus1.out_msg,
                bus1.out_last, bus1.out_parity_ok, bus1.in_ready);
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
    initial begin
        int ph;
        ph = 0;
        bus0.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus0.out_ready = 1'b1;
                1: begin
                    bus0.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: bus0.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input int mi, input int mn, input int smn, input bit [5:0] sg);
        int waited;
        waited = 0;
        bus0.in_valid    = 1'b1;
        bus0.in_min_idx  = IDXW'(mi);
        bus0.in_min_mag  = W'(mn);
        bus0.in_smin_mag = W'(smn);
        bus0.in_signs    = sg;
        forever begin
            @(negedge clk);
            if (bus0.in_ready) begin
                for (int k = 0; k < DEGREE; k++) begin
                    q0.push_back('{k, model_msg(0, k, mi, mn, smn, sg), k == DEGREE - 1, ~(^sg)});
                    q1.push_back('{k, model_msg(2, k, mi, mn, smn, sg), k == DEGREE - 1, ~(^sg)});
                end
                @(posedge clk);
                #1;
                bus0.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 0, 1);
                bus0.in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        int n;
        checks = 0;
        failures = 0;
        rmode = 0;
        for (int d = 0; d < 2; d++) begin
            stalled[d] = 0;
            run[d] = 0;
            maxrun[d] = 0;
            beats[d] = 0;
            held[d] = '0;
        end
        bus0.in_valid = 1'b0;
        bus0.in_min_idx = '0;
        bus0.in_min_mag = '0;
        bus0.in_smin_mag = '0;
        bus0.in_signs = '0;
        rst_n = 1'b0;
        #23;
        check("rst_out_valid", int'(bus0.out_valid), 0);
        check("rst_out_idx", int'(bus0.out_idx), 0);
        check("rst_out_msg", int'(bus0.out_msg), 0);
        check("rst_out_last", int'(bus0.out_last), 0);
        check("rst_parity_ok", int'(bus0.out_parity_ok), 0);
        check("rst_in_ready", int'(bus0.in_ready), 1);
        check("rst_out_valid_dut1", int'(bus1.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed record, full throughput
        send(2, 3, 9, 6'b000101);
        drain();

        // Same record with a stalling consumer
        rmode = 1;
        b = beats[0];
        send(2, 3, 9, 6'b000101);
        drain();
        check("stall_handshakes", beats[0] - b, DEGREE);
        rmode = 0;

        // Back-to-back records must stream without a bubble
        maxrun[0] = 0;
        send(1, 4, 6, 6'b110000);
        send(4, 10, 20, 6'b011111);
        drain();
        check("b2b_run", maxrun[0] >= 2 * DEGREE ? 1 : 0, 1);

        // Offset and saturation corner, then out-of-range min_idx
        send(0, 1, 128, 6'b000001);
        drain();
        send(7, 5, 1, 6'b000000);
        drain();
        send(5, 128, 128, 6'b111111);
        drain();

        // Reset in the middle of a record
        b = beats[0];
        send(3, 7, 11, 6'b100110);
        n = 0;
        while (beats[0] < b + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("mid_reset_reach_idx2", beats[0] - b, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(bus0.out_valid), 0);
        check("async_rst_out_valid_dut1", int'(bus1.out_valid), 0);
        check("async_rst_out_idx", int'(bus0.out_idx), 0);
        q0.delete();
        q1.delete();
        stalled[0] = 0;
        stalled[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", int'(bus0.out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(2, 6, 8, 6'b001000);
        drain();

        // Randomised records against a randomly stalling consumer
        rmode = 2;
        for (int r = 0; r < 40; r++) begin
            send($urandom_range(0, 7), $urandom_range(0, 128), $urandom_range(0, 128),
                 6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
